// File: rtl/enc8x3_serializer.sv
// rtl/enc8x3_serializer.sv - serializes an 8-bit request vector into one 3-bit index per beat.
// Optional emitted-code counter on codes_total when ENC_STATS_EN is defined.
module enc8x3_serializer #(
  parameter int MSB_FIRST = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_code,
  output logic        out_last,
  output logic        busy,
  output logic [3:0]  vec_cnt,
  output logic [15:0] codes_total
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  pending;
  logic [3:0]  cnt;
  logic [2:0]  sel_idx;
  logic        sel_last;
  logic        accept;
  logic        beat;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'd0, v[i]};
    end
    return s;
  endfunction

  // Later loop iterations win, so the scan direction sets the priority.
  always_comb begin
    sel_idx = 3'd0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (pending[i]) sel_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pending[i]) sel_idx = 3'(i);
      end
    end
  end

  assign sel_last = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);
  assign accept   = in_valid && in_ready;
  assign beat     = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && (in_vec != 8'd0)) state_nxt = EMIT;
      EMIT: if (out_ready && sel_last)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_code  = 3'd0;
    out_last  = 1'b0;
    case (state)
      IDLE: in_ready = en && !rst;
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_code  = sel_idx;
        out_last  = sel_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 8'd0;
      cnt     <= 4'd0;
    end else if (state == IDLE) begin
      if (accept && (in_vec != 8'd0)) begin
        pending <= in_vec;
        cnt     <= popcount8(in_vec);
      end
    end else if (out_ready) begin
      pending <= pending & ~(8'd1 << sel_idx);
      if (sel_last) cnt <= 4'd0;
    end
  end

  assign vec_cnt = cnt;

`ifdef ENC_STATS_EN
  logic [15:0] total_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q <= 16'd0;
    end else if (beat && (total_q != 16'hFFFF)) begin
      total_q <= total_q + 16'd1;
    end
  end

  assign codes_total = total_q;
`else
  assign codes_total = 16'h0000;
`endif

endmodule

// File: tb/tb_enc8x3_serializer.sv
// tb/tb_enc8x3_serializer.sv - directed bench for enc8x3_serializer with a queue-based reference model.
`timescale 1ns/1ps
module tb_enc8x3_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [7:0]  in_vec;
  logic        out_ready;

  logic        in_ready_l, out_valid_l, out_last_l, busy_l;
  logic [2:0]  out_code_l;
  logic [3:0]  vec_cnt_l;
  logic [15:0] codes_total_l;
  logic        in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [2:0]  out_code_m;
  logic [3:0]  vec_cnt_m;
  logic [15:0] codes_total_m;

  int n_vec = 0;
  int n_err = 0;

  int          q_l[$];
  int          q_m[$];
  int          m_cnt = 0;
  logic [15:0] m_total = 16'd0;

  int cap_l[$];
  int cap_m[$];
  int cap_last_l[$];

  always #5 clk = ~clk;

  enc8x3_serializer #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_l),
    .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
    .out_code(out_code_l), .out_last(out_last_l), .busy(busy_l),
    .vec_cnt(vec_cnt_l), .codes_total(codes_total_l)
  );

  enc8x3_serializer #(.MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready_m),
    .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_code(out_code_m), .out_last(out_last_m), .busy(busy_m),
    .vec_cnt(vec_cnt_m), .codes_total(codes_total_m)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the pending codes of the current vector, in emission order.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q_l.delete();
        q_m.delete();
        m_cnt   = 0;
        m_total = 16'd0;
      end else if (q_l.size() > 0) begin
        if (out_ready) begin
          void'(q_l.pop_front());
          void'(q_m.pop_front());
          if (m_total != 16'hFFFF) m_total = m_total + 16'd1;
          if (q_l.size() == 0) m_cnt = 0;
        end
      end else if (in_valid && en && in_vec != 8'd0) begin
        for (int i = 0; i < 8; i++) begin
          if (in_vec[i]) begin
            q_l.push_back(i);
            q_m.push_front(i);
          end
        end
        m_cnt = q_l.size();
      end
    end
  end

  initial begin
    logic        e_rdy, e_val, e_last_l, e_last_m;
    logic [2:0]  e_code_l, e_code_m;
    logic [15:0] e_tot;
    forever begin
      @(negedge clk);
      e_rdy    = !rst && en && (q_l.size() == 0);
      e_val    = (q_l.size() > 0);
      e_code_l = e_val ? 3'(q_l[0]) : 3'd0;
      e_code_m = e_val ? 3'(q_m[0]) : 3'd0;
      e_last_l = (q_l.size() == 1);
      e_last_m = (q_m.size() == 1);
`ifdef ENC_STATS_EN
      e_tot = m_total;
`else
      e_tot = 16'd0;
`endif
      chk("in_ready_l", {15'd0, in_ready_l}, {15'd0, e_rdy});
      chk("out_valid_l", {15'd0, out_valid_l}, {15'd0, e_val});
      chk("busy_l", {15'd0, busy_l}, {15'd0, e_val});
      chk("out_code_l", {13'd0, out_code_l}, {13'd0, e_code_l});
      chk("out_last_l", {15'd0, out_last_l}, {15'd0, e_last_l});
      chk("vec_cnt_l", {12'd0, vec_cnt_l}, 16'(m_cnt));
      chk("codes_total_l", codes_total_l, e_tot);
      chk("in_ready_m", {15'd0, in_ready_m}, {15'd0, e_rdy});
      chk("out_valid_m", {15'd0, out_valid_m}, {15'd0, e_val});
      chk("out_code_m", {13'd0, out_code_m}, {13'd0, e_code_m});
      chk("out_last_m", {15'd0, out_last_m}, {15'd0, e_last_m});
      chk("vec_cnt_m", {12'd0, vec_cnt_m}, 16'(m_cnt));
      chk("codes_total_m", codes_total_m, e_tot);
      if (out_valid_l && out_ready) begin
        cap_l.push_back(int'(out_code_l));
        cap_last_l.push_back(int'(out_last_l));
      end
      if (out_valid_m && out_ready) cap_m.push_back(int'(out_code_m));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap;
    cap_l.delete();
    cap_m.delete();
    cap_last_l.delete();
  endtask

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
    in_vec   = 8'd0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q_l.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (q_l.size() != 0) chk("drain_timeout", 16'd1, 16'd0);
  endtask

  task automatic chk_seq(input string name, input int exp_n,
                         input int e0, input int e1, input int e2, input int e3,
                         input int m0, input int m1, input int m2, input int m3);
    int el[4];
    int em[4];
    el = '{e0, e1, e2, e3};
    em = '{m0, m1, m2, m3};
    chk({name, "_n"}, 16'(cap_l.size()), 16'(exp_n));
    chk({name, "_nm"}, 16'(cap_m.size()), 16'(exp_n));
    for (int i = 0; i < exp_n && i < cap_l.size() && i < cap_m.size(); i++) begin
      chk({name, "_lsb"}, 16'(cap_l[i]), 16'(el[i]));
      chk({name, "_msb"}, 16'(cap_m[i]), 16'(em[i]));
      chk({name, "_last"}, 16'(cap_last_l[i]), (i == exp_n - 1) ? 16'd1 : 16'd0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_vec = 8'd0; out_ready = 1'b1;
    tick(); tick();
    en = 1'b1;
    #1;
    chk("rst_in_ready", {15'd0, in_ready_l}, 16'd0);
    chk("rst_out_valid", {15'd0, out_valid_l}, 16'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {15'd0, in_ready_l}, 16'd1);

    // en gating
    en = 1'b0; in_valid = 1'b1; in_vec = 8'h81;
    clear_cap();
    repeat (5) tick();
    chk("gated_in_ready", {15'd0, in_ready_l}, 16'd0);
    chk("gated_no_beat", 16'(cap_l.size()), 16'd0);
    en = 1'b1;
    tick();
    in_valid = 1'b0; in_vec = 8'd0;
    chk("h81_vec_cnt", {12'd0, vec_cnt_l}, 16'd2);
    drain();
    chk_seq("h81", 2, 0, 7, 0, 0, 7, 0, 0, 0);

    // full vector at full throughput
    clear_cap();
    send(8'hA5);
    chk("a5_vec_cnt", {12'd0, vec_cnt_l}, 16'd4);
    repeat (3) tick();
    chk("a5_last_beat", {15'd0, out_last_l}, 16'd1);
    tick();
    chk("a5_in_ready_after", {15'd0, in_ready_l}, 16'd1);
    chk_seq("a5", 4, 0, 2, 5, 7, 7, 5, 2, 0);

    // backpressure
    clear_cap();
    out_ready = 1'b0;
    send(8'h12);
    repeat (3) begin
      chk("stall_code", {13'd0, out_code_l}, 16'd1);
      chk("stall_last", {15'd0, out_last_l}, 16'd0);
      tick();
    end
    out_ready = 1'b1;
    drain();
    chk_seq("h12", 2, 1, 4, 0, 0, 4, 1, 0, 0);

    // zero and single-bit vectors
    clear_cap();
    send(8'h00);
    tick();
    chk("zero_busy", {15'd0, busy_l}, 16'd0);
    chk("zero_no_beat", 16'(cap_l.size()), 16'd0);
    send(8'h40);
    drain();
    chk_seq("h40", 1, 6, 0, 0, 0, 6, 0, 0, 0);

    // reset mid-vector
    send(8'hFF);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {15'd0, out_valid_l}, 16'd0);
    chk("midrst_busy", {15'd0, busy_l}, 16'd0);
    chk("midrst_vec_cnt", {12'd0, vec_cnt_l}, 16'd0);
    chk("midrst_codes_total", codes_total_l, 16'd0);
    chk("midrst_in_ready", {15'd0, in_ready_l}, 16'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_release_in_ready", {15'd0, in_ready_l}, 16'd1);

    // statistics and saturation
    repeat (8) begin
      send(8'hFF);
      drain();
    end
`ifdef ENC_STATS_EN
    chk("stats_64", codes_total_l, 16'd64);
`else
    chk("stats_off_64", codes_total_l, 16'd0);
`endif
    repeat (8192) begin
      send(8'hFF);
      drain();
    end
`ifdef ENC_STATS_EN
    chk("stats_sat", codes_total_l, 16'hFFFF);
`else
    chk("stats_off_sat", codes_total_l, 16'd0);
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
